// File: rtl/cache_pkg.sv
// Shared definitions for the cache line-miss AXI engine: FSM state encoding,
// AXI response codes and the line-alignment helper.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  // Clears the byte-offset-within-line bits of an address.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned off_bits);
    logic [31:0] mask;
    mask = '1;
    mask = mask << off_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_beat_cnt.sv
// Burst beat counter: synchronous clear on load, increment per accepted beat,
// and a flag marking the final beat of a line.
module cache_beat_cnt #(
  parameter int unsigned N = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic                                 i_load,
  input  logic                                 i_inc,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_cnt,
  output logic                                 o_last
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == W'(N - 1));

endmodule

// File: rtl/cache_axi_engine.sv
// Line-miss engine: optional victim write-back burst followed by a line fill
// burst over AXI, reporting completion and sticky error status.
module cache_axi_engine
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [5:0]  CACHE_ID   = 6'h01
) (
  input  logic                          cclk,
  input  logic                          cresetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wb,
  input  logic [31:0]                   req_fill_addr,
  input  logic [31:0]                   req_wb_addr,
  output logic [$clog2(LINE_WORDS)-1:0] wb_idx,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [DATA_W-1:0]             fill_data,
  output logic                          done,
  output logic                          err,
  output logic                          cm_arvalid,
  input  logic                          cm_arready,
  output logic [31:0]                   cm_araddr,
  input  logic                          mc_rvalid,
  output logic                          mc_rready,
  input  logic [DATA_W-1:0]             mc_rdata,
  input  logic [5:0]                    mc_rid,
  input  logic [1:0]                    mc_rresp,
  input  logic                          mc_rlast,
  output logic                          cm_awvalid,
  input  logic                          cm_awready,
  output logic [31:0]                   cm_awaddr,
  output logic                          cm_wvalid,
  input  logic                          cm_wready,
  output logic [DATA_W-1:0]             cm_wdata,
  output logic                          cm_wlast,
  input  logic                          mc_bvalid,
  input  logic [1:0]                    mc_bresp,
  output logic                          mc_bready
);

  localparam int unsigned IDX_W    = $clog2(LINE_WORDS);
  localparam int unsigned OFF_BITS = $clog2(LINE_WORDS * DATA_W / 8);

  state_t              r_state;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_done;
  logic                r_err_o;
  logic                r_err;
  logic                r_fill_valid;
  logic [IDX_W-1:0]    r_fill_idx;
  logic [DATA_W-1:0]   r_fill_data;
  logic [31:0]         r_awaddr;
  logic [31:0]         r_araddr;

  logic [IDX_W-1:0]    w_wcnt;
  logic                w_wlast;
  logic                w_wload;
  logic                w_winc;
  logic [IDX_W-1:0]    w_rcnt;
  logic                w_rlast_cnt;
  logic                w_rload;
  logic                w_rinc;
  logic                w_rx_ok;
  logic                w_r_err;
  logic                w_r_exit;

  assign w_wload = (r_state == ST_AW) && cm_awready;
  assign w_winc  = (r_state == ST_W) && r_wvalid && cm_wready;
  assign w_rload = (r_state == ST_AR) && cm_arready;
  assign w_rinc  = w_rx_ok;

  cache_beat_cnt #(.N(LINE_WORDS)) u_wcnt (
    .i_clk  (cclk),
    .i_rstn (cresetn),
    .i_load (w_wload),
    .i_inc  (w_winc),
    .o_cnt  (w_wcnt),
    .o_last (w_wlast)
  );

  cache_beat_cnt #(.N(LINE_WORDS)) u_rcnt (
    .i_clk  (cclk),
    .i_rstn (cresetn),
    .i_load (w_rload),
    .i_inc  (w_rinc),
    .o_cnt  (w_rcnt),
    .o_last (w_rlast_cnt)
  );

  // Foreign-ID beats are still handshaken (rready high) but never counted.
  assign w_rx_ok  = (r_state == ST_R) && r_rready && mc_rvalid && (mc_rid == CACHE_ID);
  assign w_r_err  = (mc_rresp != AXI_OKAY) || (w_rlast_cnt != mc_rlast);
  assign w_r_exit = w_rx_ok && (w_rlast_cnt || mc_rlast);

  always_ff @(posedge cclk) begin
    if (!cresetn) begin
      r_state      <= ST_IDLE;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_done       <= 1'b0;
      r_err_o      <= 1'b0;
      r_err        <= 1'b0;
      r_fill_valid <= 1'b0;
      r_fill_idx   <= '0;
      r_fill_data  <= '0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
    end else begin
      r_fill_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_awaddr <= line_align(req_wb_addr, OFF_BITS);
            r_araddr <= line_align(req_fill_addr, OFF_BITS);
            if (req_wb) begin
              r_awvalid <= 1'b1;
              r_state   <= ST_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end
        ST_AW: begin
          if (cm_awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (cm_wready && w_wlast) begin
            r_wvalid <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= ST_B;
          end
        end
        ST_B: begin
          if (mc_bvalid) begin
            r_bready  <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= ST_AR;
            if (mc_bresp != AXI_OKAY) r_err <= 1'b1;
          end
        end
        ST_AR: begin
          if (cm_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (w_rx_ok) begin
            r_fill_valid <= 1'b1;
            r_fill_idx   <= w_rcnt;
            r_fill_data  <= mc_rdata;
            if (w_r_err) r_err <= 1'b1;
            if (w_r_exit) begin
              r_rready <= 1'b0;
              r_done   <= 1'b1;
              r_err_o  <= r_err || w_r_err;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_err_o <= 1'b0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign wb_idx     = w_wcnt;
  assign fill_valid = r_fill_valid;
  assign fill_idx   = r_fill_idx;
  assign fill_data  = r_fill_data;
  assign done       = r_done;
  assign err        = r_err_o;
  assign cm_arvalid = r_arvalid;
  assign cm_araddr  = r_araddr;
  assign mc_rready  = r_rready;
  assign cm_awvalid = r_awvalid;
  assign cm_awaddr  = r_awaddr;
  assign cm_wvalid  = r_wvalid;
  assign cm_wdata   = wb_data;
  assign cm_wlast   = r_wvalid && w_wlast;
  assign mc_bready  = r_bready;

endmodule

// File: tb/tb_cache_axi_engine.sv
// Directed bench for cache_axi_engine: a table of miss scenarios driven through
// a scripted AXI slave, plus reset and completion corner cases.
module tb_cache_axi_engine;

  localparam int unsigned LW = 8;

  logic        cclk = 1'b0;
  logic        cresetn;
  logic        req_valid, req_wb;
  logic [31:0] req_fill_addr, req_wb_addr;
  logic [2:0]  wb_idx;
  logic [31:0] wb_data;
  logic        fill_valid;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        done, err, req_ready;
  logic        cm_arvalid, cm_arready;
  logic [31:0] cm_araddr;
  logic        mc_rvalid, mc_rready;
  logic [31:0] mc_rdata;
  logic [5:0]  mc_rid;
  logic [1:0]  mc_rresp;
  logic        mc_rlast;
  logic        cm_awvalid, cm_awready;
  logic [31:0] cm_awaddr;
  logic        cm_wvalid, cm_wready;
  logic [31:0] cm_wdata;
  logic        cm_wlast;
  logic        mc_bvalid, mc_bready;
  logic [1:0]  mc_bresp;

  int total = 0;
  int bad   = 0;

  always #5 cclk = ~cclk;

  // Victim array model: asynchronous read of the indexed word.
  always_comb wb_data = 32'hA5A5_0000 | 32'(wb_idx);

  cache_axi_engine #(.DATA_W(32), .LINE_WORDS(LW), .CACHE_ID(6'h01)) dut (
    .cclk(cclk), .cresetn(cresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
    .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done), .err(err),
    .cm_arvalid(cm_arvalid), .cm_arready(cm_arready), .cm_araddr(cm_araddr),
    .mc_rvalid(mc_rvalid), .mc_rready(mc_rready), .mc_rdata(mc_rdata),
    .mc_rid(mc_rid), .mc_rresp(mc_rresp), .mc_rlast(mc_rlast),
    .cm_awvalid(cm_awvalid), .cm_awready(cm_awready), .cm_awaddr(cm_awaddr),
    .cm_wvalid(cm_wvalid), .cm_wready(cm_wready), .cm_wdata(cm_wdata),
    .cm_wlast(cm_wlast),
    .mc_bvalid(mc_bvalid), .mc_bresp(mc_bresp), .mc_bready(mc_bready)
  );

  typedef struct {
    logic        wb;
    logic [31:0] fill_addr;
    logic [31:0] wb_addr;
    int          aw_delay;
    int          ar_delay;
    logic        wtoggle;
    logic [7:0]  foreign_mask;
    int          rresp_beat;
    logic [1:0]  bresp;
    int          rlast_beat;
    int          abort_beat;
    logic [31:0] exp_araddr;
    logic [31:0] exp_awaddr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic wb, logic [31:0] fa, logic [31:0] wa, int awd, int ard,
                              logic wt, logic [7:0] fm, int rb, logic [1:0] br, int rl,
                              int ab, logic [31:0] ea, logic [31:0] ew, logic ee);
    vec_t v;
    v.wb = wb; v.fill_addr = fa; v.wb_addr = wa; v.aw_delay = awd; v.ar_delay = ard;
    v.wtoggle = wt; v.foreign_mask = fm; v.rresp_beat = rb; v.bresp = br;
    v.rlast_beat = rl; v.abort_beat = ab; v.exp_araddr = ea; v.exp_awaddr = ew;
    v.exp_err = ee;
    return v;
  endfunction

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_wb = 0; req_fill_addr = '0; req_wb_addr = '0;
    cm_arready = 0; mc_rvalid = 0; mc_rdata = '0; mc_rid = '0; mc_rresp = '0;
    mc_rlast = 0; cm_awready = 0; cm_wready = 0; mc_bvalid = 0; mc_bresp = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 1);
    chk({tag, ".awvalid"}, 32'(cm_awvalid), 0);
    chk({tag, ".wvalid"}, 32'(cm_wvalid), 0);
    chk({tag, ".wlast"}, 32'(cm_wlast), 0);
    chk({tag, ".bready"}, 32'(mc_bready), 0);
    chk({tag, ".arvalid"}, 32'(cm_arvalid), 0);
    chk({tag, ".rready"}, 32'(mc_rready), 0);
    chk({tag, ".fill_valid"}, 32'(fill_valid), 0);
    chk({tag, ".fill_idx"}, 32'(fill_idx), 0);
    chk({tag, ".fill_data"}, fill_data, 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".wb_idx"}, 32'(wb_idx), 0);
    chk({tag, ".araddr"}, cm_araddr, 0);
    chk({tag, ".awaddr"}, cm_awaddr, 0);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int n;
    int b;
    int nb;
    logic [31:0] exp_d;
    v = vecs[vi];

    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    chk("req_ready_before_accept", 32'(req_ready), 1);
    req_valid = 1; req_wb = v.wb; req_fill_addr = v.fill_addr; req_wb_addr = v.wb_addr;
    step();
    req_valid = 0;
    chk("req_ready_after_accept", 32'(req_ready), 0);

    if (v.wb) begin
      n = 0;
      while (!cm_awvalid && n < 20) begin step(); n++; end
      chk("awvalid", 32'(cm_awvalid), 1);
      for (int d = 0; d < v.aw_delay; d++) begin
        step();
        chk("awvalid_held", 32'(cm_awvalid), 1);
      end
      chk("awaddr", cm_awaddr, v.exp_awaddr);
      cm_awready = 1;
      step();
      cm_awready = 0;

      b = 0; n = 0;
      while (b < LW && n < 100) begin
        if (v.wtoggle && (n % 2 == 1)) begin
          cm_wready = 0;
          step();
          chk("wvalid_held", 32'(cm_wvalid), 1);
        end else begin
          cm_wready = 1;
          chk("wvalid", 32'(cm_wvalid), 1);
          chk("wb_idx", 32'(wb_idx), 32'(b));
          chk("wlast", 32'(cm_wlast), 32'(b == LW - 1));
          chk("wdata", cm_wdata, 32'hA5A5_0000 | 32'(b));
          if (v.abort_beat > 0 && b == v.abort_beat) begin
            cresetn = 0;
            step();
            idle_inputs();
            chk_reset_outputs("abort");
            cresetn = 1;
            return;
          end
          step();
          b++;
        end
        n++;
      end
      cm_wready = 0;
      chk("w_beats", 32'(b), LW);
      chk("wvalid_after_burst", 32'(cm_wvalid), 0);

      n = 0;
      while (!mc_bready && n < 20) begin step(); n++; end
      chk("bready", 32'(mc_bready), 1);
      mc_bvalid = 1; mc_bresp = v.bresp;
      step();
      mc_bvalid = 0; mc_bresp = '0;
    end

    n = 0;
    while (!cm_arvalid && n < 20) begin step(); n++; end
    chk("arvalid", 32'(cm_arvalid), 1);
    for (int d = 0; d < v.ar_delay; d++) begin
      step();
      chk("arvalid_held", 32'(cm_arvalid), 1);
    end
    chk("araddr", cm_araddr, v.exp_araddr);
    cm_arready = 1;
    step();
    cm_arready = 0;

    nb = (v.rlast_beat < LW - 1) ? v.rlast_beat + 1 : LW;
    for (int rb = 0; rb < nb; rb++) begin
      if (v.foreign_mask[rb]) begin
        chk("rready_foreign", 32'(mc_rready), 1);
        mc_rvalid = 1; mc_rid = 6'h02; mc_rdata = 32'hBAD0_0000; mc_rresp = '0; mc_rlast = 0;
        step();
        chk("fill_valid_foreign", 32'(fill_valid), 0);
      end
      exp_d = 32'hC0DE_0000 | (32'(vi) << 8) | 32'(rb);
      chk("rready", 32'(mc_rready), 1);
      mc_rvalid = 1; mc_rid = 6'h01; mc_rdata = exp_d;
      mc_rresp = (rb == v.rresp_beat) ? 2'b10 : 2'b00;
      mc_rlast = (rb == v.rlast_beat);
      step();
      chk("fill_valid", 32'(fill_valid), 1);
      chk("fill_idx", 32'(fill_idx), 32'(rb));
      chk("fill_data", fill_data, exp_d);
      if (rb < nb - 1) chk("done_early", 32'(done), 0);
    end
    mc_rvalid = 0; mc_rid = '0; mc_rresp = '0; mc_rlast = 0;
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 32'(v.exp_err));
    chk("rready_off", 32'(mc_rready), 0);
    step();
    chk("done_pulse_end", 32'(done), 0);
    chk("err_cleared", 32'(err), 0);
    chk("fill_valid_end", 32'(fill_valid), 0);
    chk("req_ready_next", 32'(req_ready), 1);
  endtask

  initial begin
    vecs[0] = mk(0, 32'h1000_0004, 32'h0, 0, 0, 0, 8'h00, -1, 2'b00, 7, 0,
                 32'h1000_0000, 32'h0, 0);
    vecs[1] = mk(1, 32'h3000_001C, 32'h2000_0020, 3, 1, 1, 8'h00, -1, 2'b00, 7, 0,
                 32'h3000_0000, 32'h2000_0020, 0);
    vecs[2] = mk(0, 32'h4000_0040, 32'h0, 0, 2, 0, 8'b0000_1010, 3, 2'b00, 7, 0,
                 32'h4000_0040, 32'h0, 1);
    vecs[3] = mk(0, 32'h5000_0000, 32'h0, 0, 0, 0, 8'h00, -1, 2'b00, 7, 0,
                 32'h5000_0000, 32'h0, 0);
    vecs[4] = mk(1, 32'h6100_0011, 32'h6000_003F, 0, 0, 0, 8'h00, -1, 2'b10, 7, 0,
                 32'h6100_0000, 32'h6000_0020, 1);
    vecs[5] = mk(0, 32'h6800_0060, 32'h0, 0, 0, 0, 8'h00, -1, 2'b00, 5, 0,
                 32'h6800_0060, 32'h0, 1);
    vecs[6] = mk(1, 32'h7100_0000, 32'h7000_0000, 1, 0, 1, 8'h00, -1, 2'b00, 7, 4,
                 32'h7100_0000, 32'h7000_0000, 0);
    vecs[7] = mk(0, 32'h8000_0010, 32'h0, 0, 0, 0, 8'h01, -1, 2'b00, 7, 0,
                 32'h8000_0000, 32'h0, 0);

    idle_inputs();
    cresetn = 0;
    repeat (3) step();
    chk_reset_outputs("reset");
    cresetn = 1;
    step();

    for (int i = 0; i < 8; i++) run_vec(i);

    // A request held high through a whole miss must not start a second one
    // until the engine returns to idle.
    req_valid = 1; req_wb = 0; req_fill_addr = 32'h9000_0000; req_wb_addr = '0;
    step();
    chk("hold_req_arvalid", 32'(cm_arvalid), 1);
    step();
    chk("hold_req_not_ready", 32'(req_ready), 0);
    req_valid = 0;
    cresetn = 0;
    step();
    cresetn = 1;
    chk_reset_outputs("reset_in_ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_axi_engine.md
CACHE_AXI_ENGINE -- requirements
Module: cache_axi_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width (32 or 64).
REQ-002 SHALL have parameter LINE_WORDS, default 8, words per line (power of 2, 2..16).
REQ-003 SHALL have parameter CACHE_ID, default 6'h01, AXI ID issued and matched.
REQ-004 cclk  in  1  clock; one clock, all logic on rising edge.
REQ-005 cresetn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  line-miss request from cache array.
REQ-007 req_ready  out  1  engine idle, request accepted when both high.
REQ-008 req_wb  in  1  victim dirty: write back before fill.
REQ-009 req_fill_addr  in  32  address of line to fetch.
REQ-010 req_wb_addr  in  32  address of victim line.
REQ-011 wb_idx  out  log2(LINE_WORDS)  victim word index to array (asynchronous read).
REQ-012 wb_data  in  DATA_W  victim word at wb_idx, same cycle.
REQ-013 fill_valid  out  1  fill word write strobe to array.
REQ-014 fill_idx  out  log2(LINE_WORDS)  fill word index.
REQ-015 fill_data  out  DATA_W  fill word.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  error status, valid with done.
REQ-018 cm_arvalid  out  1  read address valid.
REQ-019 cm_arready  in  1  read address ready.
REQ-020 cm_araddr  out  32  line-aligned fill address.
REQ-021 mc_rvalid  in  1  read data valid.
REQ-022 mc_rready  out  1  read data ready.
REQ-023 mc_rdata  in  DATA_W  read data.
REQ-024 mc_rid  in  6  read ID.
REQ-025 mc_rresp  in  2  read response.
REQ-026 mc_rlast  in  1  last read beat.
REQ-027 cm_awvalid  out  1  write address valid.
REQ-028 cm_awready  in  1  write address ready.
REQ-029 cm_awaddr  out  32  line-aligned victim address.
REQ-030 cm_wvalid  out  1  write data valid.
REQ-031 cm_wready  in  1  write data ready.
REQ-032 cm_wdata  out  DATA_W  equals wb_data.
REQ-033 cm_wlast  out  1  high on beat LINE_WORDS-1.
REQ-034 mc_bvalid  in  1  write response valid.
REQ-035 mc_bready  out  1  write response ready.
Function
REQ-036 FSM states IDLE, AW, W, B, AR, R, DONE; req_ready=1 only in IDLE; on accept latch both addresses with low log2(LINE_WORDS*DATA_W/8) bits cleared, go AW if req_wb else AR; req_valid outside IDLE ignored.
REQ-037 AW: cm_awvalid=1 until cm_awready, then W; W: cm_wvalid=1, wb_idx=beat counter from 0, counter increments on cm_wvalid&cm_wready, after beat LINE_WORDS-1 go B; B: mc_bready=1, on mc_bvalid go AR, mc_bresp!=0 sets sticky err.
REQ-038 AR: cm_arvalid=1 until cm_arready, then R; cm_arvalid/awvalid never deassert before handshake; ID=CACHE_ID, len=LINE_WORDS-1, size=log2(DATA_W/8), INCR are tied by the instantiating top from parameters.
REQ-039 R: mc_rready=1; beat accepted when mc_rvalid&mc_rid==CACHE_ID; foreign-ID beats consumed and dropped; each accepted beat drives fill_valid/fill_idx/fill_data registered, one cycle later; mc_rresp!=0 sets sticky err.
REQ-040 R exits to DONE on accepted beat LINE_WORDS-1; mc_rlast on any other beat, or absent on that beat, sets err; early rlast also exits to DONE.
REQ-041 DONE lasts one cycle: done=1, err=sticky flag, then IDLE with err flag cleared; next request accepted the following cycle earliest.
REQ-042 Counter wraps only by reset to 0 on entering W and R; LINE_WORDS=2 boundary: wlast on first beat index 1 exactly.
Reset
REQ-043 cresetn=0 at any clock edge, mid-burst included, SHALL force IDLE, counters 0, err flag 0, all valid/ready/done/err/fill outputs 0, addresses 0; no burst completion attempted.
Structure
REQ-044 State encoding and AXI OKAY constant in shared package cache_pkg; one sub-module natural: cache_beat_cnt (load/increment/last-beat counter) instanced for W and R.
Verification
REQ-045 Clean miss, req_wb=0, fill_addr 0x1000_0004, 8 beats ID 1 OKAY -> araddr 0x1000_0000, fill_idx 0..7 data matches, done=1 err=0.
REQ-046 Dirty miss, wb_addr 0x2000_0020, awready delayed 3 cycles, wready toggled -> 8 W beats idx 0..7, wlast on 8th only, then AR, done err=0.
REQ-047 Read beats interleaved with ID 6'h02 and rresp=2'b10 on beat 3 -> foreign beats not written, done with err=1, next request err=0.
REQ-048 cresetn low during beat 4 of W -> next cycle all outputs 0, req_ready=1, new request completes normally.
